mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the word-index width; the array depth SHALL be 2^ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, giving the extra data-port wait states per request (range 0..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all other ports are listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address_to_im  input  32  instruction byte address.
REQ-007 data_from_im  output  32  registered instruction word.
REQ-008 dm_read  input  1  data read request.
REQ-009 dm_write  input  1  data write request.
REQ-010 read_address_to_dm  input  32  data read byte address.
REQ-011 write_address_to_dm  input  32  data write byte address.
REQ-012 data_to_dm  input  32  write data.
REQ-013 data_from_dm  output  32  read data, held until the next read completes.
REQ-014 dm_ready  output  1  one-cycle completion pulse.
REQ-015 dm_err  output  1  one-cycle error pulse, coincident with dm_ready.

Function
REQ-016 Word index for either port SHALL be address[ADDR_WIDTH+1:2]; address bits above that SHALL be ignored, so addresses wrap.
REQ-017 The instruction port SHALL update data_from_im every edge from the indexed word, with 1-cycle latency and no handshake.
REQ-018 The data FSM SHALL have states IDLE, BUSY and DONE.
REQ-019 In IDLE, an edge with dm_read or dm_write high SHALL latch the op, the address (write address if dm_write, else read address) and data_to_dm, then go to BUSY with the wait counter loaded with WAIT_CYCLES.
REQ-020 In BUSY, the wait counter SHALL decrement each edge while nonzero; at the edge where it is zero the access SHALL be performed and the FSM SHALL go to DONE.
REQ-021 A write access SHALL commit the latched data to the array; a read access SHALL load data_from_dm.
REQ-022 In DONE, dm_ready SHALL be 1 for exactly that cycle, and the next edge SHALL return to IDLE.
REQ-023 Latency SHALL be WAIT_CYCLES+2 edges from accept to the dm_ready cycle; the minimum request spacing SHALL be WAIT_CYCLES+3 cycles.
REQ-024 Requests present in BUSY or DONE SHALL be ignored and not queued; the requester holds them until it sees dm_ready.
REQ-025 If dm_read and dm_write are both high at accept, the write SHALL be performed, data_from_dm SHALL be unchanged, and dm_err SHALL pulse.
REQ-026 If the latched address[1:0] is not 0, the array SHALL NOT be written, a read SHALL load data_from_dm with 0, and dm_err SHALL pulse.
REQ-027 An instruction read of a word written at the same edge SHALL return the old value (read-before-write).
REQ-028 Input changes while in BUSY SHALL NOT affect the latched address or data.

Reset
REQ-029 Reset SHALL force the FSM to IDLE, clear the wait counter, and set data_from_im, data_from_dm, dm_ready and dm_err to 0 immediately, without waiting for a clock edge.
REQ-030 Array contents SHALL NOT be reset and SHALL be retained across reset.
REQ-031 Reset asserted in BUSY SHALL abort the request with no array write; the first request after release SHALL be accepted normally.

Verification
REQ-032 WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 -> dm_ready pulses 2 edges after accept, dm_err=0; then read 0x10 -> data_from_dm=0xDEADBEEF with the dm_ready pulse.
REQ-033 WAIT_CYCLES=3: read request -> dm_ready exactly 5 edges after accept; a second request held through BUSY is accepted only after DONE.
REQ-034 Write to 0x13 -> dm_err=1 with dm_ready, and the word at 0x10 is unchanged; read 0x22 -> data_from_dm=0, dm_err=1.
REQ-035 dm_read=dm_write=1, write address 0x20, data 0x5 -> word 8 becomes 0x5, dm_err=1, data_from_dm unchanged.
REQ-036 ADDR_WIDTH=8: write 0xA5 at 0x400, then address_to_im=0x0 -> data_from_im=0xA5 one edge later (wrap); an instruction read at the commit edge returns the old word.
REQ-037 Reset pulsed mid-BUSY of a write -> outputs 0 at once, no dm_ready, target word unchanged; a read after release completes normally.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose : word-addressed 32-bit memory with a free-running instruction port and a data port driven by a request FSM.
// Latency : instruction port 1 edge; data port WAIT_CYCLES+2 edges from accept (accept edge included) to the dm_ready cycle.
// Backpr. : one request at a time; requests seen in BUSY/DONE are ignored, so the requester holds them until dm_ready.
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   address_to_im / data_from_im    instruction byte address in, registered word out
//   dm_read, dm_write               data-port request strobes
//   read_address_to_dm              byte address used for a read
//   write_address_to_dm             byte address used for a write (also for read+write)
//   data_to_dm                      write data
//   data_from_dm                    read data, held until the next read completes
//   dm_ready, dm_err                one-cycle completion pulse and coincident error flag
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_to_im,
    output logic [31:0] data_from_im,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] read_address_to_dm,
    input  logic [31:0] write_address_to_dm,
    input  logic [31:0] data_to_dm,
    output logic [31:0] data_from_dm,
    output logic        dm_ready,
    output logic        dm_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mem [DEPTH];

    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_nxt;

    // Request captured at accept; only the bits that select a word or
    // flag misalignment are kept, higher address bits simply wrap.
    logic                  op_write;
    logic                  op_both;
    logic [ADDR_WIDTH+1:0] op_addr;
    logic [31:0]           op_data;

    logic                  accept;
    logic                  perform;
    logic                  misaligned;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic [ADDR_WIDTH-1:0] im_idx;

    // Address bits that never select a word; gathered here so they are
    // visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_to_im[31:ADDR_WIDTH+2],
                                address_to_im[1:0],
                                read_address_to_dm[31:ADDR_WIDTH+2],
                                write_address_to_dm[31:ADDR_WIDTH+2]};

    // A write (alone or together with a read) always targets the write address.
    assign req_addr   = dm_write ? write_address_to_dm[ADDR_WIDTH+1:0]
                                 : read_address_to_dm[ADDR_WIDTH+1:0];
    assign op_idx     = op_addr[ADDR_WIDTH+1:2];
    assign im_idx     = address_to_im[ADDR_WIDTH+1:2];
    assign misaligned = (op_addr[1:0] != 2'b00);

    // op_write covers the read+write collision, which is executed as a write,
    // so a colliding request never touches data_from_dm.
    assign wr_en = perform &  op_write & ~misaligned;
    assign rd_en = perform & ~op_write;

    // ---------------------------------------------------------------
    // Data-port FSM: next state and control strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        perform      = 1'b0;
        case (state)
            IDLE: begin
                if (dm_read || dm_write) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    perform   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Request latch: loaded only on accept, so input activity during
    // BUSY/DONE cannot disturb an access in flight.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write <= 1'b0;
            op_both  <= 1'b0;
            op_addr  <= '0;
            op_data  <= 32'd0;
        end else if (accept) begin
            op_write <= dm_write;
            op_both  <= dm_read & dm_write;
            op_addr  <= req_addr;
            op_data  <= data_to_dm;
        end
    end

    // ---------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_from_im <= 32'd0;
            data_from_dm <= 32'd0;
            dm_ready     <= 1'b0;
            dm_err       <= 1'b0;
        end else begin
            // Sampled from the array before this edge's write lands,
            // giving read-before-write on a same-edge collision.
            data_from_im <= mem[im_idx];
            // Raised on the edge that performs the access, i.e. visible
            // during DONE, and cleared on the edge leaving DONE.
            dm_ready     <= perform;
            dm_err       <= perform & (op_both | misaligned);
            if (rd_en) begin
                data_from_dm <= misaligned ? 32'd0 : mem[op_idx];
            end
        end
    end

    // ---------------------------------------------------------------
    // Storage: deliberately not reset so contents survive a reset.
    // A reset during BUSY forces IDLE, which drops perform and hence
    // the write enable, aborting the pending write.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[op_idx] <= op_data;
        end
    end

endmodule
